// File: rtl/tube_r3_xfer.sv
// tube_r3_xfer -- parasite-side tube register-3 block-transfer engine.
// Services PNMI requests from the tube by moving one byte (or two in
// two-byte mode) between tube register 3 and parasite memory. It replaces
// the per-byte NMI handler on the parasite CPU.
//
// Ports
//   p_phi2, p_rst        clock, synchronous active-high reset
//   start, dir, two_byte transfer request; dir 0 = tube->mem, 1 = mem->tube
//   base, len            first memory address, byte count (0 = finish at once)
//   abort                stop after the byte in flight
//   p_nmi_b              tube PNMI (active low, synchronous)
//   p_addr/p_cs_b/p_rdnw/p_wdata/p_rdata   tube parasite bus
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   memory port
//   busy, done, remaining                  status
module tube_r3_xfer #(
  parameter int unsigned AW      = 16,
  parameter int unsigned LW      = 16,
  parameter int unsigned TCYC    = 2,
  parameter int unsigned HOLDOFF = 3
) (
  input  logic          p_phi2,
  input  logic          p_rst,
  input  logic          start,
  input  logic          dir,
  input  logic          two_byte,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          abort,
  input  logic          p_nmi_b,
  output logic [2:0]    p_addr,
  output logic          p_cs_b,
  output logic          p_rdnw,
  output logic [7:0]    p_wdata,
  input  logic [7:0]    p_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] remaining
);

  localparam int unsigned TW    = (TCYC > 1) ? $clog2(TCYC) : 1;
  localparam int unsigned HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned TLAST = (TCYC > 0) ? TCYC - 1 : 0;
  localparam int unsigned HLAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  typedef enum logic [2:0] {
    IDLE, WAIT_NMI, MEM_RD, TUBE, MEM_WR, NEXT, HOLD, FIN
  } state_t;

  state_t        state_q, state_d;
  logic          dir_q, two_q, busy_q, abort_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q, rem_dec;
  logic [1:0]    burst_q, burst_dec;
  logic [TW-1:0] tcnt_q;
  logic [HW-1:0] hcnt_q;
  logic [7:0]    twdata_q, mwdata_q;
  logic          tube_last, hold_last, stop;

  assign rem_dec   = rem_q - LW'(1);
  assign burst_dec = burst_q - 2'd1;
  assign tube_last = (tcnt_q == TW'(TLAST));
  assign hold_last = (hcnt_q == HW'(HLAST));
  // abort is a pulse; abort_q remembers one seen mid-byte so the byte can
  // finish and the engine still stops at the next decision point.
  assign stop      = abort | abort_q;

  assign p_addr    = 3'h5;
  assign p_wdata   = twdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mwdata_q;
  assign busy      = busy_q;
  assign remaining = rem_q;

  always_ff @(posedge p_phi2) begin
    if (p_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    p_cs_b  = 1'b1;
    p_rdnw  = 1'b1;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE:     if (start) state_d = (len == '0) ? FIN : WAIT_NMI;
      WAIT_NMI: begin
        if (stop)          state_d = FIN;
        else if (!p_nmi_b) state_d = dir_q ? MEM_RD : TUBE;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = TUBE;
      end
      TUBE: begin
        p_cs_b = 1'b0;
        p_rdnw = ~dir_q;
        if (tube_last) state_d = dir_q ? NEXT : MEM_WR;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = NEXT;
      end
      NEXT: begin
        if (rem_dec == '0 || stop) state_d = FIN;
        else if (burst_dec != '0)  state_d = dir_q ? MEM_RD : TUBE;
        else                       state_d = HOLD;
      end
      HOLD: if (hold_last) state_d = WAIT_NMI;
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_phi2) begin
    if (p_rst) begin
      dir_q    <= 1'b0;
      two_q    <= 1'b0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      burst_q  <= '0;
      tcnt_q   <= '0;
      hcnt_q   <= '0;
      twdata_q <= '0;
      mwdata_q <= '0;
    end else begin
      tcnt_q <= (state_q == TUBE && !tube_last) ? tcnt_q + TW'(1) : '0;
      hcnt_q <= (state_q == HOLD && !hold_last) ? hcnt_q + HW'(1) : '0;
      if (abort && state_q != IDLE && state_q != FIN) abort_q <= 1'b1;
      unique case (state_q)
        IDLE: if (start) begin
          rem_q <= len;
          if (len != '0) begin
            dir_q   <= dir;
            two_q   <= two_byte;
            addr_q  <= base;
            burst_q <= two_byte ? 2'd2 : 2'd1;
            busy_q  <= 1'b1;
          end
        end
        MEM_RD: if (mem_ack) twdata_q <= mem_rdata;
        TUBE:   if (tube_last && !dir_q) mwdata_q <= p_rdata;
        NEXT: begin
          addr_q  <= addr_q + AW'(1);
          rem_q   <= rem_dec;
          burst_q <= burst_dec;
        end
        HOLD: if (hold_last) burst_q <= two_q ? 2'd2 : 2'd1;
        FIN: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_r3_xfer.sv
module tb_tube_r3_xfer;
  localparam int unsigned AW = 16, LW = 16, TCYC = 2, HOLDOFF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          p_rst = 1'b1, start = 1'b0, dir = 1'b0, two_byte = 1'b0, abort = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          p_nmi_b = 1'b1;
  logic [7:0]    p_rdata = '0, mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [2:0]    p_addr;
  logic          p_cs_b, p_rdnw, mem_req, mem_we, busy, done;
  logic [7:0]    p_wdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] remaining;

  tube_r3_xfer #(.AW(AW), .LW(LW), .TCYC(TCYC), .HOLDOFF(HOLDOFF)) dut (
    .p_phi2(clk), .p_rst(p_rst), .start(start), .dir(dir), .two_byte(two_byte),
    .base(base), .len(len), .abort(abort), .p_nmi_b(p_nmi_b),
    .p_addr(p_addr), .p_cs_b(p_cs_b), .p_rdnw(p_rdnw), .p_wdata(p_wdata), .p_rdata(p_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .remaining(remaining)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected events pushed by the stimulus, popped by the monitor.
  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
  wr_t        exp_mem_q[$];
  logic [7:0] exp_tube_q[$];
  logic [15:0] exp_done_q[$];
  logic [7:0] tube_data[$];          // bytes the tube offers on R3 reads
  logic [7:0] bmem [0:65535];        // parasite memory model

  int   cs_len = 0, credit = 0, gap = 0, mwait = 0;
  int   acc_cnt = 0, memreq_cnt = 0, done_cnt = 0;
  int   clear_req = 0, clear_seen = 0;
  int   bsize = 1;
  logic cur_dir = 1'b0, hold_ack = 1'b0, req_prev = 1'b0, last_rdnw = 1'b1;
  logic [7:0] last_wdata = '0;

  // Tube, NMI and memory models plus the checking monitor.
  always @(negedge clk) begin : monitor
    wr_t  e;
    logic exp_rw;
    if (clear_seen != clear_req) begin
      clear_seen = clear_req;
      credit = 0; cs_len = 0; p_nmi_b = 1'b1; gap = $urandom_range(0, 3);
    end
    if (!p_rst) begin
      // tube side: every access must be covered by an NMI grant
      if (!p_cs_b) begin
        if (cs_len == 0) begin
          acc_cnt++;
          check("nmi_credit", 64'(credit > 0), 64'(1));
          if (credit > 0) credit--;
          p_nmi_b = 1'b1;
          exp_rw = ~cur_dir;
          check("tube_addr", 64'(p_addr), 64'(5));
          check("tube_rdnw", 64'(p_rdnw), 64'(exp_rw));
        end
        cs_len++;
        last_rdnw  = p_rdnw;
        last_wdata = p_wdata;
      end else if (cs_len != 0) begin
        check("tube_cs_len", 64'(cs_len), 64'(TCYC));
        if (!last_rdnw) begin
          check("tube_wq_nonempty", 64'(exp_tube_q.size() != 0), 64'(1));
          if (exp_tube_q.size() != 0)
            check("tube_wdata", 64'(last_wdata), 64'(exp_tube_q.pop_front()));
        end else if (tube_data.size() != 0) begin
          void'(tube_data.pop_front());
        end
        cs_len = 0;
      end
      // NMI re-raised a random gap after the previous grant is used up
      if (p_nmi_b && credit == 0 && p_cs_b && cs_len == 0) begin
        if (gap == 0) begin
          p_nmi_b = 1'b0; credit = bsize; gap = $urandom_range(0, 4);
        end else gap--;
      end
      // memory side
      if (mem_req && !req_prev) memreq_cnt++;
      req_prev = mem_req;
      if (mem_ack) begin
        mem_ack = 1'b0;
        check("mem_req_drops_after_ack", 64'(mem_req), 64'(0));
        mwait = $urandom_range(0, 2);
      end else if (mem_req && !hold_ack) begin
        exp_rw = ~cur_dir;
        check("mem_we_dir", 64'(mem_we), 64'(exp_rw));
        if (mwait == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            bmem[mem_addr] = mem_wdata;
            check("mem_wq_nonempty", 64'(exp_mem_q.size() != 0), 64'(1));
            if (exp_mem_q.size() != 0) begin
              e = exp_mem_q.pop_front();
              check("mem_waddr", 64'(mem_addr), 64'(e.addr));
              check("mem_wdata", 64'(mem_wdata), 64'(e.data));
            end
          end else mem_rdata = bmem[mem_addr];
        end else mwait--;
      end
      if (done) begin
        done_cnt++;
        check("done_q_nonempty", 64'(exp_done_q.size() != 0), 64'(1));
        if (exp_done_q.size() != 0)
          check("done_remaining", 64'(remaining), 64'(exp_done_q.pop_front()));
      end
    end
    p_rdata = (tube_data.size() != 0) ? tube_data[0] : 8'h00;
  end

  task automatic do_reset();
    @(posedge clk); #1 p_rst = 1'b1;
    @(posedge clk); #1 p_rst = 1'b0;
  endtask

  // One transfer: n bytes requested, k expected to move (k < n only with abort).
  task automatic run_xfer(input logic d, input logic tb, input logic [15:0] b,
                          input logic [15:0] n, input int abort_acc, input int k,
                          input logic fixed, input logic abort_with_start);
    int a0, m0, d0, t;
    logic [7:0] v;
    logic [15:0] a;
    cur_dir = d; bsize = tb ? 2 : 1;
    tube_data.delete();
    for (int i = 0; i < int'(n); i++) begin
      a = b + 16'(i);
      if (!d) begin
        v = fixed ? 8'(8'hA1 + i) : 8'($urandom);
        tube_data.push_back(v);
        if (i < k) exp_mem_q.push_back('{addr: a, data: v});
      end else begin
        v = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
        bmem[a] = v;
        if (i < k) exp_tube_q.push_back(v);
      end
    end
    exp_done_q.push_back(16'(int'(n) - k));
    clear_req++;
    a0 = acc_cnt; m0 = memreq_cnt; d0 = done_cnt;
    @(posedge clk); #1 dir = d; two_byte = tb; base = b; len = n; start = 1'b1;
    abort = abort_with_start;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    dir = 1'($urandom); two_byte = 1'($urandom); base = 16'($urandom); len = 16'($urandom);
    if (n == 0) check("len0_done_timing", 64'(done), 64'(1));
    else begin
      @(posedge clk); #1 start = 1'b1;   // must be ignored while busy
      @(posedge clk); #1 start = 1'b0;
    end
    if (abort_acc > 0) begin
      t = 0;
      while (acc_cnt < a0 + abort_acc && t < 2000) begin @(posedge clk); t++; end
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 3000) begin @(posedge clk); t++; end
    check("done_seen", 64'(done_cnt != d0), 64'(1));
    if (done_cnt == d0) do_reset();
    @(posedge clk); #1;
    check("busy_after_done", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt - d0), 64'(1));
    check("tube_access_count", 64'(acc_cnt - a0), 64'(k));
    check("mem_req_count", 64'(memreq_cnt - m0), 64'(k));
    check("mem_q_drained", 64'(exp_mem_q.size()), 64'(0));
    check("tube_q_drained", 64'(exp_tube_q.size()), 64'(0));
    exp_mem_q.delete(); exp_tube_q.delete(); exp_done_q.delete();
  endtask

  localparam logic [56:0] RST_VEC = {1'b1, 1'b1, 3'h5, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000};

  task automatic check_reset_outputs(input string name);
    logic [56:0] act;
    act = {p_cs_b, p_rdnw, p_addr, p_wdata, mem_req, mem_we, mem_addr, mem_wdata, busy, done, remaining};
    check(name, 64'(act), 64'(RST_VEC));
  endtask

  initial begin : stim
    int t;
    logic dd, tt;
    logic [15:0] bb, nn;
    repeat (3) @(posedge clk);
    #1 p_rst = 1'b0;
    check_reset_outputs("reset_values");

    run_xfer(1'b0, 1'b0, 16'h1000, 16'd3, 0, 3, 1'b1, 1'b1);  // start+abort together: start wins
    run_xfer(1'b1, 1'b1, 16'h2000, 16'd4, 0, 4, 1'b1, 1'b0);
    run_xfer(1'b0, 1'b0, 16'h3000, 16'd0, 0, 0, 1'b0, 1'b0);
    run_xfer(1'b0, 1'b0, 16'h4000, 16'd5, 2, 2, 1'b0, 1'b0);  // abort in 2nd byte
    run_xfer(1'b0, 1'b0, 16'hFFFF, 16'd2, 0, 2, 1'b0, 1'b0);  // address wrap

    @(posedge clk); #1 abort = 1'b1;                          // abort while idle
    @(posedge clk); #1 abort = 1'b0;
    run_xfer(1'b1, 1'b0, 16'h5000, 16'd3, 0, 3, 1'b0, 1'b0);

    // reset while a memory write is stalled
    cur_dir = 1'b0; bsize = 1; hold_ack = 1'b1;
    tube_data.delete();
    for (int i = 0; i < 3; i++) tube_data.push_back(8'($urandom));
    clear_req++;
    @(posedge clk); #1 dir = 1'b0; two_byte = 1'b0; base = 16'h6000; len = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (!(mem_req && mem_we) && t < 2000) begin @(posedge clk); #1; t++; end
    check("memwr_reached", 64'(mem_req && mem_we), 64'(1));
    p_rst = 1'b1;
    @(posedge clk); #1 p_rst = 1'b0;
    check_reset_outputs("reset_mid_memwr");
    hold_ack = 1'b0;
    run_xfer(1'b0, 1'b1, 16'h7000, 16'd3, 0, 3, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      dd = 1'($urandom);
      tt = 1'($urandom);
      bb = (i % 4 == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
      nn = 16'($urandom_range(1, 7));
      run_xfer(dd, tt, bb, nn, 0, int'(nn), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
